// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the forward and inverse S-box datapaths.
// Latency: none (types and combinational functions only).
// Backpressure: not applicable.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTES   = 16;

    typedef logic [7:0]             byte_t;
    typedef logic [AES_STATE_W-1:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_e;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254, which also maps 0 to 0
    function automatic byte_t gf_inv(input byte_t a);
        byte_t r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, a);
        end
        return r;
    endfunction

    function automatic byte_t sbox_fwd(input byte_t a);
        byte_t x;
        byte_t b;
        x = gf_inv(a);
        for (int i = 0; i < 8; i++) begin
            b[i] = x[i] ^ x[3'(i + 4)] ^ x[3'(i + 5)] ^ x[3'(i + 6)] ^ x[3'(i + 7)];
        end
        return b ^ 8'h63;
    endfunction

    function automatic byte_t sbox_inv(input byte_t a);
        byte_t b;
        for (int i = 0; i < 8; i++) begin
            b[i] = a[3'(i + 2)] ^ a[3'(i + 5)] ^ a[3'(i + 7)];
        end
        return gf_inv(b ^ 8'h05);
    endfunction

endpackage

// File: rtl/s_box.sv
// Combinational AES S-box lanes (s_box forward; inv_s_box only with SUB_BYTES_INV_MODE_EN).
// Latency: 0 cycles, pure combinational.
// Backpressure: none, no state.
module s_box
    import aes_pkg::*;
(
    input  byte_t a,
    output byte_t s
);
    assign s = sbox_fwd(a);
endmodule

`ifdef SUB_BYTES_INV_MODE_EN
module inv_s_box
    import aes_pkg::*;
(
    input  byte_t a,
    output byte_t s
);
    assign s = sbox_inv(a);
endmodule
`endif

// File: rtl/sub_bytes_serial.sv
// Serial AES SubBytes over a 128-bit state, BYTES_PER_CYCLE S-box lanes (inverse option: SUB_BYTES_INV_MODE_EN).
// Latency: out_valid rises 16/BYTES_PER_CYCLE edges after the accept edge.
// Backpressure: result held in DONE until out_ready; in_ready follows out_ready there for back-to-back blocks.
module sub_bytes_serial
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 1
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data,
    output logic                   busy
`ifdef SUB_BYTES_INV_MODE_EN
    ,
    input  logic                   inv
`endif
);

    localparam int NUM_CHUNKS = AES_BYTES / BYTES_PER_CYCLE;
    localparam int CHUNK_W    = 8 * BYTES_PER_CYCLE;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
        $error("sub_bytes_serial: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    fsm_e               fsm_q, fsm_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    state_t             state_q, state_d;
    logic [CHUNK_W-1:0] chunk_in;
    logic [CHUNK_W-1:0] chunk_out;
`ifdef SUB_BYTES_INV_MODE_EN
    logic               inv_q, inv_d;
`endif

    // Chunk 0 is the most significant slice, so byte 0 is substituted first
    always_comb begin
        chunk_in = '0;
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            if (cnt_q == CNT_W'(c)) chunk_in = state_q[AES_STATE_W-1-c*CHUNK_W -: CHUNK_W];
        end
    end

    for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_lane
        byte_t fwd;
        s_box u_s_box (.a(chunk_in[CHUNK_W-1-8*l -: 8]), .s(fwd));
`ifdef SUB_BYTES_INV_MODE_EN
        byte_t rev;
        inv_s_box u_inv_s_box (.a(chunk_in[CHUNK_W-1-8*l -: 8]), .s(rev));
        assign chunk_out[CHUNK_W-1-8*l -: 8] = inv_q ? rev : fwd;
`else
        assign chunk_out[CHUNK_W-1-8*l -: 8] = fwd;
`endif
    end

    always_comb begin
        fsm_d     = fsm_q;
        cnt_d     = cnt_q;
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
`ifdef SUB_BYTES_INV_MODE_EN
        inv_d     = inv_q;
`endif
        case (fsm_q)
            IDLE: in_ready = 1'b1;
            BUSY: begin
                busy = 1'b1;
                for (int c = 0; c < NUM_CHUNKS; c++) begin
                    if (cnt_q == CNT_W'(c)) state_d[AES_STATE_W-1-c*CHUNK_W -: CHUNK_W] = chunk_out;
                end
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    fsm_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready && !in_valid) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
        // A new block may be taken from IDLE or, back-to-back, from DONE
        if (in_valid && in_ready) begin
            state_d = in_data;
            cnt_d   = '0;
            fsm_d   = BUSY;
`ifdef SUB_BYTES_INV_MODE_EN
            inv_d   = inv;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            cnt_q   <= '0;
            state_q <= '0;
`ifdef SUB_BYTES_INV_MODE_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
`ifdef SUB_BYTES_INV_MODE_EN
            inv_q   <= inv_d;
`endif
        end
    end

    assign out_data = state_q;

endmodule

// File: tb/tb_sub_bytes_serial.sv
// Directed bench for sub_bytes_serial: one instance per legal BYTES_PER_CYCLE sharing inputs.
// Latency: n/a. Backpressure: exercised through out_ready stalls.
module tb_sub_bytes_serial;

    localparam logic [127:0] VEC_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] VEC_SB  = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [127:0] ALL_63  = {16{8'h63}};
    localparam logic [127:0] ALL_53  = {16{8'h53}};
    localparam logic [127:0] ALL_ED  = {16{8'hed}};
    localparam logic [127:0] ALL_FF  = {16{8'hff}};
    localparam logic [127:0] ALL_16  = {16{8'h16}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic         inv;
    logic [127:0] in_data;
    logic [4:0]   ir, ov, bz;
    logic [127:0] od [5];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        sub_bytes_serial #(.BYTES_PER_CYCLE(1 << g)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (ir[g]),
            .in_data  (in_data),
            .out_valid(ov[g]),
            .out_ready(out_ready),
            .out_data (od[g]),
            .busy     (bz[g])
`ifdef SUB_BYTES_INV_MODE_EN
            ,
            .inv      (inv)
`endif
        );
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input string tag, input logic [127:0] dat);
        in_valid = 1'b1;
        in_data  = dat;
        #1;
        check({tag, "_in_ready"}, ir[0], 1'b1);
        step();
        in_valid = 1'b0;
        in_data  = ~dat;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
    endtask

    task automatic wait_main(input string tag, input int exp_lat, input logic [127:0] exp_dat,
                             input bit pulse);
        int n = 0;
        while (!ov[0] && n < 24) begin
            if (pulse) begin
                in_valid = ~in_valid;
                in_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            step();
            n++;
            if (pulse && n == 5) check({tag, "_busy_rdy"}, {bz[0], ir[0]}, 2'b10);
        end
        in_valid = 1'b0;
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_dat"}, od[0], exp_dat);
    endtask

    initial begin
        int lat [5];
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        inv       = 1'b0;
        in_data   = '0;
        step();
        step();
        rst_n = 1'b1;

        for (int g = 0; g < 5; g++) begin
            check($sformatf("rst_in_ready_%0d", g), ir[g], 1'b1);
            check($sformatf("rst_out_valid_%0d", g), ov[g], 1'b0);
            check($sformatf("rst_busy_%0d", g), bz[g], 1'b0);
            check($sformatf("rst_out_data_%0d", g), od[g], '0);
        end

        // All-zero block through every lane width at once
        accept("t2", '0);
        for (int g = 0; g < 5; g++) lat[g] = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            for (int g = 0; g < 5; g++) if (lat[g] == 0 && ov[g]) lat[g] = n;
        end
        for (int g = 0; g < 5; g++) begin
            check($sformatf("t2_lat_b%0d", 1 << g), lat[g], 16 >> g);
            check($sformatf("t2_dat_b%0d", 1 << g), od[g], ALL_63);
        end
        check("t2_done_in_ready", ir[0], 1'b0);
        drain();
        check("t2_drained", ov, 5'b0);

        accept("t1", VEC_PT);
        wait_main("t1", 16, VEC_SB, 1'b0);

        drain();
        accept("t5", VEC_PT);
        wait_main("t5", 16, VEC_SB, 1'b1);

        // Stall in DONE, then release with a new block in the same cycle
        for (int n = 0; n < 20; n++) begin
            step();
            check("t3_stall_valid", ov[0], 1'b1);
            check("t3_stall_data", od[0], VEC_SB);
            check("t3_stall_in_ready", ir[0], 1'b0);
        end
        out_ready = 1'b1;
        accept("t3", ALL_53);
        out_ready = 1'b0;
        check("t3_b2b_busy", bz[0], 1'b1);
        check("t3_b2b_valid", ov[0], 1'b0);
        wait_main("t3", 16, ALL_ED, 1'b0);

        drain();
        accept("t4", VEC_PT);
        for (int n = 0; n < 7; n++) step();
        check("t4_pre_busy", bz[0], 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t4_rst_valid", ov[0], 1'b0);
        check("t4_rst_data", od[0], '0);
        check("t4_rst_in_ready", ir[0], 1'b1);
        check("t4_rst_busy", bz[0], 1'b0);
        accept("t4n", ALL_FF);
        wait_main("t4n", 16, ALL_16, 1'b0);

`ifdef SUB_BYTES_INV_MODE_EN
        drain();
        inv = 1'b1;
        accept("t6", VEC_SB);
        inv = 1'b0;
        wait_main("t6", 16, VEC_PT, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
